// File: rtl/core_pkg.sv
// Shared core definitions: ALU operation codes and the RV32I opcode/funct fields
// recognised by the decode/issue stage and the ALU.
package core_pkg;

  localparam logic [4:0] ALUOp_nop   = 5'b00000;
  localparam logic [4:0] ALUOp_lui   = 5'b00001;
  localparam logic [4:0] ALUOp_auipc = 5'b00010;
  localparam logic [4:0] ALUOp_add   = 5'b00011;
  localparam logic [4:0] ALUOp_sub   = 5'b00100;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [2:0] F3_ADD = 3'b000;

endpackage

// File: rtl/id_decode.sv
// Pure combinational decode of one RV32I instruction into ALU operands, ALUOp,
// destination register and write-back enable. Unsupported encodings become a NOP bubble.
module id_decode
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [OPW-1:0]  aluop,
  output logic [4:0]      rd,
  output logic            rf_we,
  output logic            illegal
);

  logic [XLEN-1:0] uimm;
  logic [XLEN-1:0] iimm;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            writes;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  // Both immediates are sign-extended so the stage also works for XLEN > 32.
  assign uimm = XLEN'(signed'({instr[31:12], 12'b0}));
  assign iimm = XLEN'(signed'(instr[31:20]));

  always_comb begin
    a       = '0;
    b       = '0;
    aluop   = OPW'(ALUOp_nop);
    writes  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_LUI: begin
        aluop  = OPW'(ALUOp_lui);
        b      = uimm;
        writes = 1'b1;
      end
      OP_AUIPC: begin
        aluop  = OPW'(ALUOp_auipc);
        a      = pc;
        b      = uimm;
        writes = 1'b1;
      end
      OP_R: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) begin
          aluop  = OPW'(ALUOp_add);
          a      = rs1_data;
          b      = rs2_data;
          writes = 1'b1;
        end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
          aluop  = OPW'(ALUOp_sub);
          a      = rs1_data;
          b      = rs2_data;
          writes = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        if (funct3 == F3_ADD) begin
          aluop  = OPW'(ALUOp_add);
          a      = rs1_data;
          b      = iimm;
          writes = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Writes to x0 are architecturally discarded, so never request them.
  assign rf_we = writes & (rd != 5'd0);

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue register in front of the ALU: decodes one instruction per accept and
// holds the decoded fields stable behind a valid/ready handshake, with flush support.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter int              OPW    = 5,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_A,
  output logic [XLEN-1:0] out_B,
  output logic [OPW-1:0]  out_ALUOp,
  output logic [4:0]      out_rd,
  output logic            out_rf_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [OPW-1:0]  dec_aluop;
  logic [4:0]      dec_rd;
  logic            dec_rf_we;
  logic            dec_illegal;
  logic            accept;

  id_decode #(
    .XLEN(XLEN),
    .OPW (OPW)
  ) u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .a       (dec_a),
    .b       (dec_b),
    .aluop   (dec_aluop),
    .rd      (dec_rd),
    .rf_we   (dec_rf_we),
    .illegal (dec_illegal)
  );

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Flush has priority over accept; a drained slot keeps its stale data registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_A       <= '0;
      out_B       <= '0;
      out_ALUOp   <= OPW'(ALUOp_nop);
      out_rd      <= 5'd0;
      out_rf_we   <= 1'b0;
      out_pc      <= RST_PC;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_A       <= dec_a;
      out_B       <= dec_b;
      out_ALUOp   <= dec_aluop;
      out_rd      <= dec_rd;
      out_rf_we   <= dec_rf_we;
      out_pc      <= in_pc;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
